// File: rtl/secded_pipe_dec_if.sv
// Bundles the read-path signals of the SEC-DED pipelined decoder.
//  Upstream side : Gin_vld / Gin_rdy handshake, received data Gid, received
//                  check bits Gic (MSB = overall parity), correction enable.
//  Downstream side: Gout_vld / Gout_rdy handshake, decoded data God, syndrome
//                  Gsyn, per-word error flags Gsbe / Gdbe.
//  Status        : saturating error counters and their synchronous clear.
// The decoder connects through the slave modport; the driving/consuming
// environment uses the master modport.
interface secded_pipe_dec_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);

  // Smallest r with 2^r >= DATA_W + r + 1, plus one overall parity bit.
  function automatic int calc_chk_w(input int dw);
    int r;
    r = 1;
    while ((1 << r) < dw + r + 1) r = r + 1;
    return r + 1;
  endfunction

  localparam int CHK_W = calc_chk_w(DATA_W);

  logic              Gin_vld;
  logic              Gin_rdy;
  logic [DATA_W-1:0] Gid;
  logic [CHK_W-1:0]  Gic;
  logic              Gcorr_en;
  logic              Gout_vld;
  logic              Gout_rdy;
  logic [DATA_W-1:0] God;
  logic [CHK_W-2:0]  Gsyn;
  logic              Gsbe;
  logic              Gdbe;
  logic [CNT_W-1:0]  Gsbe_cnt;
  logic [CNT_W-1:0]  Gdbe_cnt;
  logic              Gcnt_clr;

  modport slave (
    input  Gin_vld, Gid, Gic, Gcorr_en, Gout_rdy, Gcnt_clr,
    output Gin_rdy, Gout_vld, God, Gsyn, Gsbe, Gdbe, Gsbe_cnt, Gdbe_cnt
  );

  modport master (
    output Gin_vld, Gid, Gic, Gcorr_en, Gout_rdy, Gcnt_clr,
    input  Gin_rdy, Gout_vld, God, Gsyn, Gsbe, Gdbe, Gsbe_cnt, Gdbe_cnt
  );

endinterface

// File: rtl/secded_pipe_dec.sv
// Two-stage pipelined SEC-DED (extended Hamming) decoder with valid/ready
// flow control and saturating single/double error counters.
//  Gclk   : rising-edge clock
//  Grst_n : asynchronous active-low reset, empties the pipeline
//  bus    : secded_pipe_dec_if slave modport (input word + check bits,
//           decoded word + syndrome + flags, error counters, counter clear)
// Stage 1 captures the raw word, its Hamming syndrome and overall parity.
// Stage 2 classifies the error, optionally corrects one data bit, and holds
// the result until the consumer takes it.
module secded_pipe_dec #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic           Gclk,
  input  logic           Grst_n,
  secded_pipe_dec_if.slave bus
);

  function automatic int calc_r(input int dw);
    int r;
    r = 1;
    while ((1 << r) < dw + r + 1) r = r + 1;
    return r;
  endfunction

  // Code position of data bit i: the i-th position that is not a power of two.
  function automatic int data_pos(input int i);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int q = 3; q <= 256; q++) begin
      if ((q & (q - 1)) != 0) begin
        if (cnt == i) res = q;
        cnt = cnt + 1;
      end
    end
    return res;
  endfunction

  localparam int R = calc_r(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Stage 1 state
  logic              s1_vld_q,  s1_vld_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic [R-1:0]      s1_syn_q,  s1_syn_d;
  logic              s1_par_q,  s1_par_d;
  logic              s1_corr_q, s1_corr_d;

  // Stage 2 (output) state
  logic              s2_vld_q,  s2_vld_d;
  logic [DATA_W-1:0] s2_data_q, s2_data_d;
  logic [R-1:0]      s2_syn_q,  s2_syn_d;
  logic              s2_sbe_q,  s2_sbe_d;
  logic              s2_dbe_q,  s2_dbe_d;

  logic [CNT_W-1:0]  sbe_cnt_q, sbe_cnt_d;
  logic [CNT_W-1:0]  dbe_cnt_q, dbe_cnt_d;

  logic              s1_adv, s2_adv, out_xfer;
  logic [R-1:0]      calc_syn;
  logic              in_par;
  logic [DATA_W-1:0] flip_mask;
  logic              syn_hit, syn_pow2;
  logic              dec_sbe, dec_dbe;
  logic [DATA_W-1:0] dec_data;

  // A stage moves forward when it is empty or its downstream stage moves.
  always_comb begin
    s2_adv   = !s2_vld_q || bus.Gout_rdy;
    s1_adv   = !s1_vld_q || s2_adv;
    out_xfer = s2_vld_q && bus.Gout_rdy;
  end

  assign bus.Gin_rdy = s1_adv;

  // Syndrome = check bits regenerated from the data, XORed with the received
  // ones; the overall parity covers every received bit.
  always_comb begin
    calc_syn = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (bus.Gid[i]) calc_syn = calc_syn ^ R'(data_pos(i));
    end
    calc_syn = calc_syn ^ bus.Gic[R-1:0];
    in_par   = ^{bus.Gid, bus.Gic};
  end

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_data_d = s1_data_q;
    s1_syn_d  = s1_syn_q;
    s1_par_d  = s1_par_q;
    s1_corr_d = s1_corr_q;
    if (s1_adv) begin
      s1_vld_d = bus.Gin_vld;
      if (bus.Gin_vld) begin
        s1_data_d = bus.Gid;
        s1_syn_d  = calc_syn;
        s1_par_d  = in_par;
        s1_corr_d = bus.Gcorr_en;
      end
    end
  end

  // Classification: odd parity with a syndrome that names a check bit (a power
  // of two, including zero for the overall parity bit) or a data bit is a
  // single error; any other non-zero syndrome/parity combination is
  // uncorrectable. The flip mask is empty for syndromes outside the data.
  always_comb begin
    for (int i = 0; i < DATA_W; i++) begin
      flip_mask[i] = (s1_syn_q == R'(data_pos(i)));
    end
    syn_hit  = |flip_mask;
    syn_pow2 = ((s1_syn_q & (s1_syn_q - R'(1))) == '0);
    dec_sbe  = s1_par_q && (syn_pow2 || syn_hit);
    dec_dbe  = ((s1_syn_q != '0) || s1_par_q) && !dec_sbe;
    dec_data = (dec_sbe && s1_corr_q) ? (s1_data_q ^ flip_mask) : s1_data_q;
  end

  always_comb begin
    s2_vld_d  = s2_vld_q;
    s2_data_d = s2_data_q;
    s2_syn_d  = s2_syn_q;
    s2_sbe_d  = s2_sbe_q;
    s2_dbe_d  = s2_dbe_q;
    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_data_d = dec_data;
        s2_syn_d  = s1_syn_q;
        s2_sbe_d  = dec_sbe;
        s2_dbe_d  = dec_dbe;
      end
    end
  end

  // Counters count delivered words only; clear wins over an increment.
  always_comb begin
    sbe_cnt_d = sbe_cnt_q;
    dbe_cnt_d = dbe_cnt_q;
    if (bus.Gcnt_clr) begin
      sbe_cnt_d = '0;
      dbe_cnt_d = '0;
    end else if (out_xfer) begin
      if (s2_sbe_q && (sbe_cnt_q != CNT_MAX)) sbe_cnt_d = sbe_cnt_q + CNT_W'(1);
      if (s2_dbe_q && (dbe_cnt_q != CNT_MAX)) dbe_cnt_d = dbe_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Gclk or negedge Grst_n) begin
    if (!Grst_n) begin
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
      s1_syn_q  <= '0;
      s1_par_q  <= 1'b0;
      s1_corr_q <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      s2_syn_q  <= '0;
      s2_sbe_q  <= 1'b0;
      s2_dbe_q  <= 1'b0;
      sbe_cnt_q <= '0;
      dbe_cnt_q <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_data_q <= s1_data_d;
      s1_syn_q  <= s1_syn_d;
      s1_par_q  <= s1_par_d;
      s1_corr_q <= s1_corr_d;
      s2_vld_q  <= s2_vld_d;
      s2_data_q <= s2_data_d;
      s2_syn_q  <= s2_syn_d;
      s2_sbe_q  <= s2_sbe_d;
      s2_dbe_q  <= s2_dbe_d;
      sbe_cnt_q <= sbe_cnt_d;
      dbe_cnt_q <= dbe_cnt_d;
    end
  end

  assign bus.Gout_vld = s2_vld_q;
  assign bus.God      = s2_data_q;
  assign bus.Gsyn     = s2_syn_q;
  assign bus.Gsbe     = s2_sbe_q;
  assign bus.Gdbe     = s2_dbe_q;
  assign bus.Gsbe_cnt = sbe_cnt_q;
  assign bus.Gdbe_cnt = dbe_cnt_q;

endmodule

// File: tb/tb_secded_pipe_dec.sv
// Self-checking bench for secded_pipe_dec (DATA_W=32, CNT_W=4 so counter
// saturation is reachable in a few dozen words).
module tb_secded_pipe_dec;

  logic Gclk;
  logic Grst_n;

  secded_pipe_dec_if #(.DATA_W(32), .CNT_W(4)) bus ();

  secded_pipe_dec #(.DATA_W(32), .CNT_W(4)) dut (
    .Gclk   (Gclk),
    .Grst_n (Grst_n),
    .bus    (bus.slave)
  );

  initial Gclk = 1'b0;
  always #5 Gclk = ~Gclk;

  int compCount = 0;
  int failCount = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: check bit j is the XOR of data bits whose code
  // position has bit j set; bit 6 is the parity over data and check bits.
  function automatic logic [6:0] encode(input logic [31:0] d);
    logic [5:0] c;
    int idx;
    c = '0;
    idx = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[idx]) c = c ^ 6'(p);
        idx++;
      end
    end
    return {(^d) ^ (^c), c};
  endfunction

  // Present one word and drop valid right after it is taken.
  task automatic applyStimulus(input logic [31:0] d, input logic [6:0] c, input logic corr);
    int n;
    @(negedge Gclk);
    bus.Gin_vld  = 1'b1;
    bus.Gid      = d;
    bus.Gic      = c;
    bus.Gcorr_en = corr;
    n = 0;
    #1;
    while (!bus.Gin_rdy && n < 20) begin
      @(negedge Gclk);
      #1;
      n++;
    end
    if (!bus.Gin_rdy) checkOutput("in_timeout", 0, 1);
    @(negedge Gclk);
    bus.Gin_vld = 1'b0;
  endtask

  // Called on the negedge after acceptance; reports cycles from acceptance.
  task automatic waitValid(output int lat);
    lat = 1;
    while (!bus.Gout_vld && lat < 20) begin
      @(negedge Gclk);
      lat++;
    end
    if (!bus.Gout_vld) checkOutput("vld_timeout", 0, 1);
  endtask

  task automatic consume();
    bus.Gout_rdy = 1'b1;
    @(negedge Gclk);
    bus.Gout_rdy = 1'b0;
  endtask

  logic [33:0] expQ[$];

  initial begin
    int lat;
    int sent, recv, cyc, outCount;
    bit pending;
    logic [33:0] pendExp, got;
    logic [31:0] d, dRaw;
    logic [6:0]  c;
    int kind, b1, b2;

    Grst_n       = 1'b0;
    bus.Gin_vld  = 1'b0;
    bus.Gid      = '0;
    bus.Gic      = '0;
    bus.Gcorr_en = 1'b1;
    bus.Gout_rdy = 1'b0;
    bus.Gcnt_clr = 1'b0;

    #12;
    checkOutput("rst_out_vld", bus.Gout_vld, 0);
    checkOutput("rst_god", bus.God, 0);
    checkOutput("rst_sbe_cnt", bus.Gsbe_cnt, 0);
    @(negedge Gclk);
    Grst_n = 1'b1;
    @(negedge Gclk);
    checkOutput("rst_in_rdy", bus.Gin_rdy, 1);

    // 1: clean zero word, two-cycle latency
    applyStimulus(32'h0, 7'h00, 1'b1);
    waitValid(lat);
    checkOutput("t1_latency", lat, 2);
    checkOutput("t1_god", bus.God, 32'h0);
    checkOutput("t1_flags", {bus.Gsyn, bus.Gsbe, bus.Gdbe}, 0);
    consume();

    // 2: d0 flipped, corrected then only flagged
    applyStimulus(32'h1, 7'h00, 1'b1);
    waitValid(lat);
    checkOutput("t2_god", bus.God, 32'h0);
    checkOutput("t2_syn", bus.Gsyn, 3);
    checkOutput("t2_sbe", {bus.Gsbe, bus.Gdbe}, 2'b10);
    consume();
    checkOutput("t2_sbe_cnt", bus.Gsbe_cnt, 1);
    applyStimulus(32'h1, 7'h00, 1'b0);
    waitValid(lat);
    checkOutput("t2b_god", bus.God, 32'h1);
    checkOutput("t2b_sbe", bus.Gsbe, 1);
    consume();
    checkOutput("t2b_sbe_cnt", bus.Gsbe_cnt, 2);

    // 3: double error, also verify outputs hold while stalled
    applyStimulus(32'h3, 7'h00, 1'b1);
    waitValid(lat);
    @(negedge Gclk);
    checkOutput("t3_hold_vld", bus.Gout_vld, 1);
    checkOutput("t3_god", bus.God, 32'h3);
    checkOutput("t3_syn", bus.Gsyn, 6);
    checkOutput("t3_flags", {bus.Gsbe, bus.Gdbe}, 2'b01);
    consume();
    checkOutput("t3_dbe_cnt", bus.Gdbe_cnt, 1);

    // 4: check-bit and overall-parity errors
    applyStimulus(32'h0, 7'h01, 1'b1);
    waitValid(lat);
    checkOutput("t4a_syn", bus.Gsyn, 1);
    checkOutput("t4a_god", bus.God, 32'h0);
    checkOutput("t4a_flags", {bus.Gsbe, bus.Gdbe}, 2'b10);
    consume();
    applyStimulus(32'h0, 7'h40, 1'b1);
    waitValid(lat);
    checkOutput("t4b_syn", bus.Gsyn, 0);
    checkOutput("t4b_flags", {bus.Gsbe, bus.Gdbe}, 2'b10);
    consume();

    // 5: random stream with random backpressure, in-order scoreboard
    sent = 0; recv = 0; cyc = 0; pending = 0;
    pendExp = '0;
    while (recv < 64 && cyc < 3000) begin
      @(negedge Gclk);
      cyc++;
      bus.Gout_rdy = 1'($urandom_range(0, 1));
      if (!pending && sent < 64 && $urandom_range(0, 3) != 0) begin
        d = $urandom();
        c = encode(d);
        dRaw = d;
        kind = $urandom_range(0, 3);
        b1 = $urandom_range(0, 31);
        b2 = (b1 + 1 + $urandom_range(0, 30)) % 32;
        case (kind)
          1: dRaw = d ^ (32'h1 << b1);
          2: dRaw = d ^ (32'h1 << b1) ^ (32'h1 << b2);
          3: c = c ^ (7'h1 << $urandom_range(0, 6));
          default: ;
        endcase
        if (kind == 2) pendExp = {1'b1, 1'b0, dRaw};
        else           pendExp = {1'b0, (kind != 0), d};
        bus.Gin_vld  = 1'b1;
        bus.Gid      = dRaw;
        bus.Gic      = c;
        bus.Gcorr_en = 1'b1;
        pending = 1;
      end else if (!pending) begin
        bus.Gin_vld = 1'b0;
      end
      #1;
      if (bus.Gout_vld && bus.Gout_rdy) begin
        if (expQ.size() == 0) begin
          checkOutput("stream_extra", 1, 0);
        end else begin
          got = expQ.pop_front();
          checkOutput("stream_word", {bus.Gdbe, bus.Gsbe, bus.God}, got);
        end
        recv++;
      end
      if (bus.Gin_vld && bus.Gin_rdy) begin
        expQ.push_back(pendExp);
        sent++;
        pending = 0;
      end
    end
    checkOutput("stream_count", recv, 64);
    @(negedge Gclk);
    bus.Gin_vld = 1'b0;
    bus.Gout_rdy = 1'b1;

    // 5b: back-to-back traffic, one word per cycle
    outCount = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge Gclk);
      bus.Gin_vld = (k < 8);
      bus.Gid = 32'(k);
      bus.Gic = encode(32'(k));
      #1;
      if (k < 8) checkOutput("tput_in_rdy", bus.Gin_rdy, 1);
      if (bus.Gout_vld) outCount++;
    end
    checkOutput("tput_out_count", outCount, 8);

    // 6: saturation, clear-over-increment, reset with words in flight
    @(negedge Gclk);
    bus.Gcnt_clr = 1'b1;
    @(negedge Gclk);
    bus.Gcnt_clr = 1'b0;
    checkOutput("t6_clr", {bus.Gsbe_cnt, bus.Gdbe_cnt}, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge Gclk);
      bus.Gin_vld = 1'b1;
      bus.Gid = 32'h1;
      bus.Gic = 7'h00;
    end
    @(negedge Gclk);
    bus.Gin_vld = 1'b0;
    repeat (4) @(negedge Gclk);
    checkOutput("t6_sat", bus.Gsbe_cnt, 15);
    bus.Gout_rdy = 1'b0;
    applyStimulus(32'h1, 7'h00, 1'b1);
    waitValid(lat);
    bus.Gout_rdy = 1'b1;
    bus.Gcnt_clr = 1'b1;
    @(negedge Gclk);
    bus.Gout_rdy = 1'b0;
    bus.Gcnt_clr = 1'b0;
    checkOutput("t6_clr_prio", bus.Gsbe_cnt, 0);
    applyStimulus(32'h3, 7'h00, 1'b1);
    waitValid(lat);
    consume();
    checkOutput("t6_dbe_cnt", bus.Gdbe_cnt, 1);
    applyStimulus(32'h5, encode(32'h5), 1'b1);
    applyStimulus(32'h6, encode(32'h6), 1'b1);
    #2;
    Grst_n = 1'b0;
    #1;
    checkOutput("t6_rst_vld", bus.Gout_vld, 0);
    checkOutput("t6_rst_cnt", {bus.Gsbe_cnt, bus.Gdbe_cnt}, 0);
    checkOutput("t6_rst_god", bus.God, 0);
    @(negedge Gclk);
    Grst_n = 1'b1;
    bus.Gout_rdy = 1'b1;
    outCount = 0;
    repeat (5) begin
      @(negedge Gclk);
      if (bus.Gout_vld) outCount++;
    end
    checkOutput("t6_no_stale", outCount, 0);
    checkOutput("t6_in_rdy", bus.Gin_rdy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
